// File: rtl/psum_sequencer_pkg.sv
// Shared constants and types for the partial-sum sequencer.
// Output-index encoding matches the 2x2 tile accumulator's ctrl word.
// The FSM state type is shared so any observer can decode it.
package psum_sequencer_pkg;

  localparam int CTRL_VALID_BIT = 2;
  localparam int NUM_OUT        = 4;

  localparam logic [1:0] IDX_C11 = 2'b00;
  localparam logic [1:0] IDX_C12 = 2'b01;
  localparam logic [1:0] IDX_C21 = 2'b10;
  localparam logic [1:0] IDX_C22 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/psum_sequencer_row_mac.sv
// Row multiply-accumulate: running sum of truncated pixel*weight products.
// Latency: row_sum_o is combinational (stored sum + current product).
// Backpressure: none; the parent gates acc_en_i with its handshake.
module psum_sequencer_row_mac #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              acc_en_i,
  input  logic              last_tap_i,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic [DATA_W-1:0] weight_i,
  output logic [DATA_W-1:0] row_sum_o
);

  logic [DATA_W-1:0] prod_lo;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;

  // Only the low DATA_W bits of the product matter: the sum wraps mod 2^DATA_W,
  // so the self-determined DATA_W-bit multiply gives exactly those bits.
  assign prod_lo   = pixel_i * weight_i;
  assign row_sum_o = sum_q + prod_lo;

  // Next running sum: cleared at job start and after the last tap of a row.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (acc_en_i) begin
      sum_d = last_tap_i ? '0 : row_sum_o;
    end
  end

  // Running-sum register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/psum_sequencer.sv
// Feeds row partial sums with {valid, output index} to the 2x2 tile accumulator.
// Latency: p_sum/ctrl valid one cycle after the last pair of a row is accepted.
// Backpressure: in_ready high for the whole RUN phase, low in IDLE and DONE.
module psum_sequencer
  import psum_sequencer_pkg::*;
#(
  parameter int TAPS_PER_ROW = 3,
  parameter int ROWS         = 3,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic [2:0]        ctrl,
  output logic [DATA_W-1:0] p_sum,
  output logic              busy,
  output logic              done
);

  localparam int TAP_W = (TAPS_PER_ROW > 1) ? $clog2(TAPS_PER_ROW) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] p_sum_q, p_sum_d;

  logic              accept;
  logic              last_tap;
  logic              last_row;
  logic              mac_clear;
  logic [DATA_W-1:0] row_sum;

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign ctrl     = ctrl_q;
  assign p_sum    = p_sum_q;

  assign accept   = in_valid && in_ready;
  assign last_tap = (tap_q == TAP_W'(TAPS_PER_ROW - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));

  psum_sequencer_row_mac #(
    .DATA_W(DATA_W)
  ) u_row_mac (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (mac_clear),
    .acc_en_i  (accept),
    .last_tap_i(last_tap),
    .pixel_i   (pixel),
    .weight_i  (weight),
    .row_sum_o (row_sum)
  );

  // Next state, counters and the one-cycle emission word.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    row_d     = row_q;
    idx_d     = idx_q;
    ctrl_d    = 3'b000;
    p_sum_d   = '0;
    mac_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          tap_d     = '0;
          row_d     = '0;
          idx_d     = IDX_C11;
          mac_clear = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_tap) begin
            ctrl_d[CTRL_VALID_BIT] = 1'b1;
            ctrl_d[1:0]            = idx_q;
            p_sum_d                = row_sum;
            tap_d                  = '0;
            if (last_row) begin
              row_d = '0;
              idx_d = idx_q + 2'd1;
              // The last row of c22 closes the job; its emission shows during DONE.
              if (idx_q == IDX_C22) begin
                state_d = DONE;
              end
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      row_q   <= '0;
      idx_q   <= IDX_C11;
      ctrl_q  <= 3'b000;
      p_sum_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      p_sum_q <= p_sum_d;
    end
  end

endmodule

// File: tb/tb_psum_sequencer.sv
// Bench for psum_sequencer: default instance (3 taps, 3 rows) and a 1x1 instance.
// Behavioural model counts accepted pairs per job and derives emissions from that.
// Outputs are compared on every falling edge; literal checks pin key scenarios.
module tb_psum_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st  [2];
  logic       vl  [2];
  logic [7:0] px  [2];
  logic [7:0] wt  [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       dn  [2];
  logic [2:0] ctl [2];
  logic [7:0] ps  [2];

  psum_sequencer #(.TAPS_PER_ROW(3), .ROWS(3), .DATA_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .in_valid(vl[0]), .in_ready(rdy[0]),
    .pixel(px[0]), .weight(wt[0]), .ctrl(ctl[0]), .p_sum(ps[0]),
    .busy(bsy[0]), .done(dn[0]));

  psum_sequencer #(.TAPS_PER_ROW(1), .ROWS(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .in_valid(vl[1]), .in_ready(rdy[1]),
    .pixel(px[1]), .weight(wt[1]), .ctrl(ctl[1]), .p_sum(ps[1]),
    .busy(bsy[1]), .done(dn[1]));

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int taps(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int rows(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // Model: phase 0 idle, 1 running, 2 final cycle. Everything else follows
  // from the number of pairs accepted so far in the job.
  int         m_phase [2];
  int         m_cnt   [2];
  int         m_sum   [2];
  logic [2:0] e_ctl   [2];
  logic [7:0] e_ps    [2];
  logic       e_rdy   [2];
  logic       e_bsy   [2];
  logic       e_dn    [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
      e_ctl[i] = 3'b000; e_ps[i] = 8'd0;
      e_rdy[i] = 1'b0; e_bsy[i] = 1'b0; e_dn[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int prod;
    int per_job;
    per_job  = 4 * taps(i) * rows(i);
    e_ctl[i] = 3'b000;
    e_ps[i]  = 8'd0;
    if (m_phase[i] == 0) begin
      if (st[i]) begin
        m_phase[i] = 1; m_cnt[i] = 0; m_sum[i] = 0;
      end
    end else if (m_phase[i] == 1) begin
      if (vl[i]) begin
        prod     = (int'(px[i]) * int'(wt[i])) % 256;
        m_sum[i] = (m_sum[i] + prod) % 256;
        m_cnt[i]++;
        if (m_cnt[i] % taps(i) == 0) begin
          e_ctl[i] = {1'b1, 2'((m_cnt[i] - 1) / (taps(i) * rows(i)))};
          e_ps[i]  = 8'(m_sum[i]);
          m_sum[i] = 0;
          if (m_cnt[i] == per_job) m_phase[i] = 2;
        end
      end
    end else begin
      m_phase[i] = 0;
    end
    e_rdy[i] = (m_phase[i] == 1);
    e_bsy[i] = (m_phase[i] != 0);
    e_dn[i]  = (m_phase[i] == 2);
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    cyc++;
    if (!rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  // Emission logs as observed at the DUT pins.
  typedef struct {int c; int ctl; int ps; int dn;} em_t;
  em_t q0[$];
  em_t q1[$];
  int  done_cnt [2] = '{0, 0};

  // Single compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ctrl%0d", i),     32'(ctl[i]), 32'(e_ctl[i]));
      chk($sformatf("p_sum%0d", i),    32'(ps[i]),  32'(e_ps[i]));
      chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(e_rdy[i]));
      chk($sformatf("busy%0d", i),     32'(bsy[i]), 32'(e_bsy[i]));
      chk($sformatf("done%0d", i),     32'(dn[i]),  32'(e_dn[i]));
      if (dn[i] === 1'b1) done_cnt[i]++;
      if (ctl[i][2] === 1'b1) begin
        if (i == 0) q0.push_back('{cyc, int'(ctl[i]), int'(ps[i]), int'(dn[i])});
        else        q1.push_back('{cyc, int'(ctl[i]), int'(ps[i]), int'(dn[i])});
      end
    end
  end

  // Idle-side noise on instance 1: pairs offered while it is not running.
  logic noise1 = 1'b1;
  always @(negedge clk) begin
    if (noise1) begin
      vl[1] = 1'($urandom);
      px[1] = 8'($urandom);
      wt[1] = 8'($urandom);
    end
  end

  // Modes: 0 ones, 1 wrap table + start noise, 2 stalls with 2*3, 3 random.
  task automatic run_job(input int i, input int mode, input int abort_after);
    int n;
    int k;
    st[i] = 1'b1; vl[i] = 1'b0;
    @(negedge clk);
    st[i] = 1'b0;
    n = 0;
    while (m_phase[i] != 0 && n < 3000) begin
      case (mode)
        0: begin vl[i] = 1'b1; px[i] = 8'd1; wt[i] = 8'd1; end
        1: begin
          vl[i] = 1'b1;
          k = m_cnt[i];
          if (k < 3)       begin px[i] = 8'd200; wt[i] = 8'd1;  end
          else if (k == 3) begin px[i] = 8'd16;  wt[i] = 8'd16; end
          else if (k == 4) begin px[i] = 8'd1;   wt[i] = 8'd1;  end
          else if (k == 5) begin px[i] = 8'd2;   wt[i] = 8'd1;  end
          else begin px[i] = 8'($urandom); wt[i] = 8'($urandom); end
          st[i] = (m_phase[i] == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
        2: begin vl[i] = (n % 2 == 0); px[i] = 8'd2; wt[i] = 8'd3; end
        default: begin
          vl[i] = ($urandom_range(0, 3) != 0);
          px[i] = 8'($urandom); wt[i] = 8'($urandom);
        end
      endcase
      @(negedge clk);
      n++;
      if (abort_after > 0 && m_cnt[i] >= abort_after) break;
    end
    st[i] = 1'b0; vl[i] = 1'b0;
    if (n >= 3000) chk("job_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int d0;
    int bank;
    rst = 1'b0;
    st[0] = 1'b0; vl[0] = 1'b0; px[0] = 8'd0; wt[0] = 8'd0;
    st[1] = 1'b0; px[1] = 8'd0; wt[1] = 8'd0; vl[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl",     32'(ctl[0]), 32'd0);
    chk("reset_in_ready", 32'(rdy[0]), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Ones: 12 emissions of 3, one every 3 cycles, done with the final 111.
    q0.delete(); d0 = done_cnt[0];
    run_job(0, 0, -1);
    chk("ones_count", 32'(q0.size()), 32'd12);
    for (int j = 0; j < q0.size() && j < 12; j++) begin
      chk($sformatf("ones_ps%0d", j),  32'(q0[j].ps),  32'd3);
      chk($sformatf("ones_ctl%0d", j), 32'(q0[j].ctl), 32'(4 + j / 3));
      chk($sformatf("ones_dn%0d", j),  32'(q0[j].dn),  (j == 11) ? 32'd1 : 32'd0);
      if (j > 0) chk($sformatf("ones_gap%0d", j), 32'(q0[j].c - q0[j-1].c), 32'd3);
    end
    for (int b = 0; b < 4; b++) begin
      bank = 0;
      foreach (q0[j]) if ((q0[j].ctl & 3) == b) bank += q0[j].ps;
      chk($sformatf("bank%0d", b), 32'(bank), 32'd9);
    end
    chk("ones_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    // Pairs offered while idle are ignored.
    vl[0] = 1'b1; px[0] = 8'd5; wt[0] = 8'd5;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(rdy[0]), 32'd0);
    vl[0] = 1'b0;

    // Wrap and truncation, with start pulsed in RUN and DONE.
    q0.delete(); d0 = done_cnt[0];
    run_job(0, 1, -1);
    chk("wrap_count", 32'(q0.size()), 32'd12);
    if (q0.size() >= 2) begin
      chk("wrap_600", 32'(q0[0].ps), 32'd88);
      chk("trunc_16x16", 32'(q0[1].ps), 32'd3);
    end
    @(negedge clk);
    chk("start_in_done_ignored", 32'(bsy[0]), 32'd0);
    chk("wrap_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    // Stalls every other cycle: 18 per row, row every 6 cycles.
    q0.delete();
    run_job(0, 2, -1);
    chk("stall_count", 32'(q0.size()), 32'd12);
    foreach (q0[j]) chk($sformatf("stall_ps%0d", j), 32'(q0[j].ps), 32'd18);
    if (q0.size() >= 2) chk("stall_gap", 32'(q0[1].c - q0[0].c), 32'd6);

    // Random job, checked by the model only.
    q0.delete();
    run_job(0, 3, -1);
    chk("rand_count", 32'(q0.size()), 32'd12);

    // Reset mid-cycle after 10 accepted pairs.
    run_job(0, 0, 10);
    chk("abort_accepts", 32'(m_cnt[0]), 32'd10);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctrl",  32'(ctl[0]), 32'd0);
    chk("midrst_psum",  32'(ps[0]),  32'd0);
    chk("midrst_busy",  32'(bsy[0]), 32'd0);
    chk("midrst_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    run_job(0, 0, -1);
    chk("fresh_count", 32'(q0.size()), 32'd12);
    if (q0.size() >= 1) begin
      chk("fresh_ctl0", 32'(q0[0].ctl), 32'd4);
      chk("fresh_ps0",  32'(q0[0].ps),  32'd3);
    end

    // 1x1 instance: every accepted pair emits next cycle, four in total.
    noise1 = 1'b0;
    @(negedge clk);
    q1.delete(); d0 = done_cnt[1];
    run_job(1, 3, -1);
    chk("one_count", 32'(q1.size()), 32'd4);
    for (int j = 0; j < q1.size() && j < 4; j++) begin
      chk($sformatf("one_ctl%0d", j), 32'(q1[j].ctl), 32'(4 + j));
      chk($sformatf("one_dn%0d", j),  32'(q1[j].dn),  (j == 3) ? 32'd1 : 32'd0);
    end
    chk("one_done_pulses", 32'(done_cnt[1] - d0), 32'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/psum_sequencer.md
Name: psum_sequencer

Overview:
Upstream feeder for the 2x2 output-tile accumulator in the PE.
- Accepts a stream of (pixel, weight) pairs.
- Multiply-accumulates TAPS_PER_ROW pairs into one row partial sum.
- Emits each row partial sum as p_sum with a ctrl word {valid, output index}, which is exactly the accumulator's input format.
- Walks output positions c11, c12, c21, c22 in order, ROWS row sums each, then signals done.

Parameters:
TAPS_PER_ROW, 3, (pixel, weight) pairs summed per emitted p_sum (>=1)
ROWS, 3, p_sum emissions per output position (>=1)
DATA_W, 8, pixel/weight/p_sum width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: one clock; reset is asynchronous and active-low
start  in  1  begin one tile job; sampled only in IDLE
in_valid  in  1  pixel/weight valid
in_ready  out  1  sequencer accepts a pair this cycle
pixel  in  DATA_W  unsigned activation
weight  in  DATA_W  unsigned weight
ctrl  out  3  [2]=p_sum valid, [1:0]=output index (00 c11, 01 c12, 10 c21, 11 c22)
p_sum  out  DATA_W  row partial sum
busy  out  1  job in progress (RUN or DONE)
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (rst=0, async): state=IDLE; ctrl=3'b000, p_sum=0, in_ready=0, busy=0, done=0; all counters and the running sum cleared.
- Handshake: a pair is accepted when in_valid && in_ready. Inputs are ignored when in_ready=0.
- Arithmetic:
  - product = pixel*weight (2*DATA_W bits); only the low DATA_W bits are used.
  - Running sum adds modulo 2^DATA_W (unsigned wrap). This matches the accumulator's 8-bit wrap.
- FSM IDLE:
  - in_ready=0, busy=0.
  - start=1 -> RUN with tap=0, row=0, idx=0, sum=0.
- FSM RUN:
  - in_ready=1, busy=1.
  - On accept with tap<TAPS_PER_ROW-1: sum+=prod, tap++.
  - On accept with tap==TAPS_PER_ROW-1 (row complete):
    - Register p_sum=sum+prod and ctrl={1,idx}, visible the next cycle for exactly one cycle.
    - sum=0, tap=0.
    - If row<ROWS-1: row++.
    - Else row=0 and idx++; if idx was 3 -> DONE.
  - Latency: p_sum appears 1 cycle after the last pair of its row is accepted.
  - Back-to-back rows need no bubble: in_ready stays 1 through emissions.
- ctrl/p_sum in all other cycles: ctrl=3'b000, p_sum=0. The accumulator drives its output to 0 when it sees this.
- FSM DONE (one cycle):
  - in_ready=0, busy=1, done=1.
  - The final emission (ctrl=3'b111) is visible in this same cycle.
  - Next state IDLE.
- start while RUN/DONE: ignored.
- start and reset asserted together: reset wins.
- in_valid gaps: counters hold, sum holds, no emission.
- Reset mid-job: immediate return to IDLE with all outputs at reset values; partial sums discarded. Downstream accumulator banks are not cleared by this block.
- Job totals: 4*ROWS*TAPS_PER_ROW accepted pairs and 4*ROWS emissions. With defaults, 36 pairs and 12 emissions.

Decomposition:
- Shared package holds:
  - CTRL_VALID_BIT=2.
  - Index constants IDX_C11=2'b00, IDX_C12=2'b01, IDX_C21=2'b10, IDX_C22=2'b11.
  - NUM_OUT=4.
  - FSM state enum {IDLE, RUN, DONE}.
- One natural sub-module: row_mac.
  - Holds the product, the low-bits truncation and the running-sum register.
  - Ports: clear, accumulate enable, last-tap flag; outputs the completed sum.
- FSM, counters and the ctrl register stay in psum_sequencer.

Test Plan:
- Defaults, start, 36 pairs pixel=1 weight=1, in_valid held high -> 12 emissions p_sum=3, one every 3 cycles. ctrl sequence 3x100, 3x101, 3x110, 3x111. done=1 exactly with the last 111. Accumulator downstream then holds 9 in each bank.
- Wrap: row of pairs (200,1),(200,1),(200,1) -> p_sum=88 (600 mod 256). Pair (16,16) -> product contributes 0.
- Stalls: in_valid toggled 1/0 every cycle with pixel=2 weight=3 -> each p_sum=18. No emission while stalled. Emission count still 12.
- start pulsed again mid-RUN and in DONE -> ignored. Job ends after exactly 36 accepts. in_ready=0 in DONE and IDLE; a pair offered then is not counted.
- rst driven low after 10 accepted pairs, mid-cycle -> outputs immediately 0, state IDLE. After release and new start, the first emission is ctrl=100 with a fresh sum.
- TAPS_PER_ROW=1, ROWS=1 -> each accepted pair emits the next cycle. 4 emissions idx 00..11. done on the 4th.
